// File: rtl/mc_pkg.sv
// Shared constants, state encoding and control-word type for the multicycle MIPS controller.
// The ILLEGAL state exists only when MC_ILLEGAL_TRAP_EN is defined.
package mc_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_LUI   = 2'b11;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_4      = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_RTEX, S_RTWB, S_IMMEX, S_IMMWB, S_BRANCH, S_JUMP
`ifdef MC_ILLEGAL_TRAP_EN
    , S_ILLEGAL
`endif
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       ir_write;
    logic       mem_write;
    logic       memto_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic       ext_op;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       instr_done;
  } ctrl_t;

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath/memory signal bundle. The illegal flag is present only
// when MC_ILLEGAL_TRAP_EN is defined.
interface multicycle_controller_if;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, IorD, IRWrite, MemWrite;
  logic       MemtoReg, RegDst, RegWrite, ALUSrcA, Ext_op;
  logic [1:0] ALUSrcB, ALUOp, PCSrc;
  logic       instr_done;
`ifdef MC_ILLEGAL_TRAP_EN
  logic       illegal;
`endif

  modport master (
    input  opcode, mem_ready,
    output PCWrite, PCWriteCond, IorD, IRWrite, MemWrite, MemtoReg, RegDst,
           RegWrite, ALUSrcA, Ext_op, ALUSrcB, ALUOp, PCSrc, instr_done
`ifdef MC_ILLEGAL_TRAP_EN
    , output illegal
`endif
  );

  modport slave (
    output opcode, mem_ready,
    input  PCWrite, PCWriteCond, IorD, IRWrite, MemWrite, MemtoReg, RegDst,
           RegWrite, ALUSrcA, Ext_op, ALUSrcB, ALUOp, PCSrc, instr_done
`ifdef MC_ILLEGAL_TRAP_EN
    , input illegal
`endif
  );
endinterface

// File: rtl/mc_signal_decode.sv
// Combinational control-word decode: state + latched opcode + mem_ready -> datapath controls.
module mc_signal_decode
  import mc_pkg::*;
(
  input  state_t     i_state,
  input  logic [5:0] i_opcode,
  input  logic       i_mem_ready,
  output ctrl_t      o_ctrl
);

  always_comb begin
    o_ctrl = '0;
    case (i_state)
      S_FETCH: begin
        o_ctrl.alu_src_b = SRCB_4;
        o_ctrl.ir_write  = i_mem_ready;
        o_ctrl.pc_write  = i_mem_ready;
      end
      S_DECODE: o_ctrl.alu_src_b = SRCB_IMM_SH;
      S_MEMADR: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_IMM;
      end
      S_MEMRD: o_ctrl.iord = 1'b1;
      S_MEMWB: begin
        o_ctrl.memto_reg  = 1'b1;
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.instr_done = 1'b1;
      end
      S_MEMWR: begin
        o_ctrl.iord       = 1'b1;
        o_ctrl.mem_write  = 1'b1;
        o_ctrl.instr_done = i_mem_ready;
      end
      S_RTEX: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_B;
        o_ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_RTWB: begin
        o_ctrl.reg_dst    = 1'b1;
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.instr_done = 1'b1;
      end
      S_IMMEX: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_IMM;
        o_ctrl.alu_op    = (i_opcode == OP_LUI) ? ALUOP_LUI : ALUOP_ADD;
        o_ctrl.ext_op    = (i_opcode == OP_ADDIU);
      end
      S_IMMWB: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.instr_done = 1'b1;
      end
      S_BRANCH: begin
        o_ctrl.alu_src_a     = 1'b1;
        o_ctrl.alu_src_b     = SRCB_B;
        o_ctrl.alu_op        = ALUOP_SUB;
        o_ctrl.pc_src        = PCSRC_ALUOUT;
        o_ctrl.pc_write_cond = 1'b1;
        o_ctrl.instr_done    = 1'b1;
      end
      S_JUMP: begin
        o_ctrl.pc_src     = PCSRC_JUMP;
        o_ctrl.pc_write   = 1'b1;
        o_ctrl.instr_done = 1'b1;
      end
      default: o_ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle MIPS-subset control FSM: state register, next-state logic, reset gating of strobes.
// Define MC_ILLEGAL_TRAP_EN to trap unknown opcodes in a terminal ILLEGAL state.
module multicycle_controller
  import mc_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  multicycle_controller_if.master bus
);

  state_t     r_state, w_next;
  logic [5:0] r_opcode;
  ctrl_t      w_ctrl;

  // Opcode is captured in DECODE so later states ignore any IR-bus changes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_FETCH;
      r_opcode <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) r_opcode <= bus.opcode;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:  if (bus.mem_ready) w_next = S_DECODE;
      S_DECODE: begin
        case (bus.opcode)
          OP_LW, OP_SW:               w_next = S_MEMADR;
          OP_RTYPE:                   w_next = S_RTEX;
          OP_ADDI, OP_ADDIU, OP_LUI:  w_next = S_IMMEX;
          OP_BEQ:                     w_next = S_BRANCH;
          OP_J:                       w_next = S_JUMP;
`ifdef MC_ILLEGAL_TRAP_EN
          default:                    w_next = S_ILLEGAL;
`else
          default:                    w_next = S_FETCH;
`endif
        endcase
      end
      S_MEMADR: w_next = (r_opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (bus.mem_ready) w_next = S_MEMWB;
      S_MEMWR:  if (bus.mem_ready) w_next = S_FETCH;
      S_RTEX:   w_next = S_RTWB;
      S_IMMEX:  w_next = S_IMMWB;
`ifdef MC_ILLEGAL_TRAP_EN
      S_ILLEGAL: w_next = S_ILLEGAL;
`endif
      default:  w_next = S_FETCH;
    endcase
  end

  mc_signal_decode u_dec (
    .i_state     (r_state),
    .i_opcode    (r_opcode),
    .i_mem_ready (bus.mem_ready),
    .o_ctrl      (w_ctrl)
  );

  // Strobes are gated by rst so FETCH's mem_ready-driven writes cannot fire in reset.
  assign bus.PCWrite     = w_ctrl.pc_write      & ~rst;
  assign bus.PCWriteCond = w_ctrl.pc_write_cond & ~rst;
  assign bus.IRWrite     = w_ctrl.ir_write      & ~rst;
  assign bus.MemWrite    = w_ctrl.mem_write     & ~rst;
  assign bus.RegWrite    = w_ctrl.reg_write     & ~rst;
  assign bus.instr_done  = w_ctrl.instr_done    & ~rst;
  assign bus.IorD        = w_ctrl.iord;
  assign bus.MemtoReg    = w_ctrl.memto_reg;
  assign bus.RegDst      = w_ctrl.reg_dst;
  assign bus.ALUSrcA     = w_ctrl.alu_src_a;
  assign bus.Ext_op      = w_ctrl.ext_op;
  assign bus.ALUSrcB     = w_ctrl.alu_src_b;
  assign bus.ALUOp       = w_ctrl.alu_op;
  assign bus.PCSrc       = w_ctrl.pc_src;
`ifdef MC_ILLEGAL_TRAP_EN
  assign bus.illegal     = (r_state == S_ILLEGAL);
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench: per-instruction cycle timelines are derived arithmetically from
// opcode class, fetch stalls and memory stalls, then compared cycle by cycle.
module tb_multicycle_controller;
  import mc_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   nvec = 0;
  int   nerr = 0;

  multicycle_controller_if mif ();

  multicycle_controller dut (
    .clk (clk),
    .rst (rst),
    .bus (mif)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string pfx);
    chk({pfx, "_PCWrite"},     8'(mif.PCWrite),     8'd0);
    chk({pfx, "_PCWriteCond"}, 8'(mif.PCWriteCond), 8'd0);
    chk({pfx, "_IRWrite"},     8'(mif.IRWrite),     8'd0);
    chk({pfx, "_MemWrite"},    8'(mif.MemWrite),    8'd0);
    chk({pfx, "_RegWrite"},    8'(mif.RegWrite),    8'd0);
    chk({pfx, "_done"},        8'(mif.instr_done),  8'd0);
    chk({pfx, "_IorD"},        8'(mif.IorD),        8'd0);
    chk({pfx, "_ALUSrcB"},     8'(mif.ALUSrcB),     8'd1);
    chk({pfx, "_ALUOp"},       8'(mif.ALUOp),       8'd0);
    chk({pfx, "_PCSrc"},       8'(mif.PCSrc),       8'd0);
`ifdef MC_ILLEGAL_TRAP_EN
    chk({pfx, "_illegal"},     8'(mif.illegal),     8'd0);
`endif
  endtask

  // Leave reset just after a rising edge so the next negedge lies in the first FETCH cycle.
  task automatic do_reset();
    rst = 1'b1;
    mif.mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk_reset_outputs("rst_hold");
    #1 rst = 1'b0;
  endtask

  // One instruction: sf = FETCH stall cycles, sm = memory-access stall cycles.
  task automatic run_instr(input logic [5:0] op, input int sf, input int sm, input bit abort_last);
    bit is_lw, is_sw, is_rt, is_beq, is_j, is_imm, legal, wr;
    int lat, mstart;
    is_lw  = (op == OP_LW);
    is_sw  = (op == OP_SW);
    is_rt  = (op == OP_RTYPE);
    is_beq = (op == OP_BEQ);
    is_j   = (op == OP_J);
    is_imm = (op == OP_ADDI) || (op == OP_ADDIU) || (op == OP_LUI);
    legal  = is_lw | is_sw | is_rt | is_beq | is_j | is_imm;
    wr     = is_lw | is_rt | is_imm;
    lat    = is_lw ? 5 : (is_sw | is_rt | is_imm) ? 4 : (is_beq | is_j) ? 3 : 2;
    lat    = lat + sf + ((is_lw | is_sw) ? sm : 0);
    mstart = sf + 3;
    for (int c = 0; c < lat; c++) begin
      @(negedge clk);
      if (c <= sf)                           mif.mem_ready = (c == sf);
      else if ((is_lw | is_sw) && c >= mstart) mif.mem_ready = (c == mstart + sm);
      else                                   mif.mem_ready = 1'($urandom);
      mif.opcode = (c <= sf + 1) ? op : 6'($urandom);
      if (abort_last && c == lat - 1) begin
        rst = 1'b1;
        #1 chk_reset_outputs("abort");
        return;
      end
      #1;
      chk("done",     8'(mif.instr_done),  8'(legal && c == lat - 1));
      chk("RegWrite", 8'(mif.RegWrite),    8'(wr && c == lat - 1));
      chk("IRWrite",  8'(mif.IRWrite),     8'(c == sf));
      chk("PCWrite",  8'(mif.PCWrite),     8'(c == sf || (is_j && c == lat - 1)));
      chk("PCWCond",  8'(mif.PCWriteCond), 8'(is_beq && c == lat - 1));
      chk("MemWrite", 8'(mif.MemWrite),    8'(is_sw && c >= lat - 1 - sm));
`ifdef MC_ILLEGAL_TRAP_EN
      chk("illegal",  8'(mif.illegal),     8'd0);
`endif
      if (c <= sf) begin
        chk("fetch_IorD",    8'(mif.IorD),    8'd0);
        chk("fetch_ALUSrcB", 8'(mif.ALUSrcB), 8'd1);
      end
      if (c == sf + 1) chk("decode_ALUSrcB", 8'(mif.ALUSrcB), 8'd3);
      if (is_lw && c >= mstart && c <= mstart + sm) chk("memrd_IorD", 8'(mif.IorD), 8'd1);
      if (is_lw && c == lat - 1) chk("memwb_MemtoReg", 8'(mif.MemtoReg), 8'd1);
      if (is_rt && c == lat - 2) chk("rtex_ALUOp", 8'(mif.ALUOp), 8'd2);
      if (is_rt && c == lat - 1) chk("rtwb_RegDst", 8'(mif.RegDst), 8'd1);
      if (is_imm && c == lat - 2) begin
        chk("immex_ALUOp",  8'(mif.ALUOp),  (op == OP_LUI) ? 8'd3 : 8'd0);
        chk("immex_Ext_op", 8'(mif.Ext_op), 8'(op == OP_ADDIU));
      end
      if (is_beq && c == lat - 1) begin
        chk("beq_PCSrc", 8'(mif.PCSrc), 8'd1);
        chk("beq_ALUOp", 8'(mif.ALUOp), 8'd1);
      end
      if (is_j && c == lat - 1) chk("j_PCSrc", 8'(mif.PCSrc), 8'd2);
    end
  endtask

  logic [5:0] stream [8];
  logic [5:0] pool   [9];

  initial begin
    stream = '{OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, OP_ADDIU, OP_LUI};
    pool   = '{OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, OP_ADDIU, OP_LUI, 6'b111111};
    mif.opcode    = OP_RTYPE;
    mif.mem_ready = 1'b1;
    do_reset();

    // Full instruction stream, no stalls
    foreach (stream[i]) run_instr(stream[i], 0, 0, 1'b0);

    // lw with 3 MEMRD stall cycles, then FETCH with 2 stall cycles
    run_instr(OP_LW, 0, 3, 1'b0);
    run_instr(OP_RTYPE, 2, 0, 1'b0);
    run_instr(OP_SW, 1, 2, 1'b0);

    // Reset asserted in the MEMWB cycle of a lw
    run_instr(OP_LW, 0, 0, 1'b1);
    do_reset();
    run_instr(OP_ADDI, 0, 0, 1'b0);

    // Randomized instruction mix with random stalls
    for (int n = 0; n < 40; n++) begin
`ifdef MC_ILLEGAL_TRAP_EN
      run_instr(pool[$urandom_range(0, 7)], $urandom_range(0, 2), $urandom_range(0, 3), 1'b0);
`else
      run_instr(pool[$urandom_range(0, 8)], $urandom_range(0, 2), $urandom_range(0, 3), 1'b0);
`endif
    end

`ifdef MC_ILLEGAL_TRAP_EN
    // Unknown opcode traps terminally until reset
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      mif.mem_ready = (c == 0) ? 1'b1 : 1'($urandom);
      mif.opcode    = (c <= 1) ? 6'b111111 : 6'($urandom);
      #1;
      if (c >= 2) begin
        chk("trap_illegal",  8'(mif.illegal),  8'd1);
        chk("trap_PCWrite",  8'(mif.PCWrite),  8'd0);
        chk("trap_IRWrite",  8'(mif.IRWrite),  8'd0);
        chk("trap_RegWrite", 8'(mif.RegWrite), 8'd0);
        chk("trap_MemWrite", 8'(mif.MemWrite), 8'd0);
        chk("trap_done",     8'(mif.instr_done), 8'd0);
      end
    end
    do_reset();
    run_instr(OP_J, 0, 0, 1'b0);
`else
    run_instr(6'b111111, 0, 0, 1'b0);
    run_instr(6'b111111, 1, 0, 1'b0);
    run_instr(OP_BEQ, 0, 0, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Multi-cycle control FSM for the MIPS subset processor: addi, addiu, beq, j, lw, sw, lui and R-type. It sequences a shared-memory datapath (single memory for instruction and data, one ALU, IR, MDR, A/B, ALUOut registers) over 3–5 cycles per instruction. It stalls on a memory-ready handshake. ALUOp goes to the existing ALU-control decoder unchanged (00 add, 01 sub, 10 funct, 11 lui).

## Interface
- No parameters; opcodes and state codes come from `mc_pkg`.
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- opcode  input  6  IR[31:26]; stable from the cycle after the FETCH commit
- mem_ready  input  1  memory completes the current access this cycle
- PCWrite, PCWriteCond, IorD, IRWrite, MemWrite, MemtoReg, RegDst, RegWrite, ALUSrcA, Ext_op  output  1 each  datapath controls
- ALUSrcB  output  2  00 B, 01 const 4, 10 ext imm, 11 ext imm<<2
- ALUOp  output  2  to ALU-control decoder
- PCSrc  output  2  00 ALU result, 01 ALUOut, 10 jump target
- instr_done  output  1  one-cycle pulse in the final state of each instruction
- illegal  output  1  sticky illegal-opcode flag; exists only with `MC_ILLEGAL_TRAP_EN`

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTEX, RTWB, IMMEX, IMMWB, BRANCH, JUMP, plus ILLEGAL (trap build only).
- FETCH: IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00. IRWrite=PCWrite=mem_ready. Stays in FETCH while mem_ready=0; goes to DECODE on mem_ready=1.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target into ALUOut). Next state by opcode:
  - lw/sw → MEMADR
  - R → RTEX
  - addi/addiu/lui → IMMEX
  - beq → BRANCH
  - j → JUMP
  - other → FETCH, or ILLEGAL in the trap build
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Goes to MEMRD for lw, MEMWR for sw.
- MEMRD: IorD=1. Holds until mem_ready, then goes to MEMWB.
- MEMWB: RegDst=0, MemtoReg=1, RegWrite=1, done. Then FETCH.
- MEMWR: IorD=1, MemWrite=1, held until mem_ready. On mem_ready: done, then FETCH.
- RTEX: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Then RTWB.
- RTWB: RegDst=1, MemtoReg=0, RegWrite=1, done. Then FETCH.
- IMMEX: ALUSrcA=1, ALUSrcB=10. ALUOp=11 for lui, else 00. Ext_op=1 only for addiu. Then IMMWB.
- IMMWB: RegDst=0, MemtoReg=0, RegWrite=1, done. Then FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01, PCWriteCond=1, done. Then FETCH.
- JUMP: PCSrc=10, PCWrite=1, done. Then FETCH.
- Any output not listed for a state is 0.
- Write strobes (PCWrite, PCWriteCond, IRWrite, MemWrite, RegWrite) are forced to 0 while rst=1.

## Timing
- Reset: state=FETCH immediately and asynchronously. While rst=1, all strobes are 0 and instr_done=0. Mux selects show their FETCH values. illegal=0.
- First fetch is attempted on the first rising edge after rst deasserts.
- Outputs are Moore-decoded from the state register, except the mem_ready-gated strobes in FETCH and MEMWR.
- Latency with mem_ready=1 throughout:
  - beq, j: 3 cycles
  - R-type, sw, addi, addiu, lui: 4 cycles
  - lw: 5 cycles
- Each cycle with mem_ready low in FETCH, MEMRD or MEMWR adds one cycle.
- mem_ready is ignored in all other states.
- rst asserted mid-instruction abandons it, with no partial register write after the assertion.
- opcode is sampled only in DECODE. Changes outside DECODE have no effect.

## Configuration
- `MC_ILLEGAL_TRAP_EN` defined:
  - An unknown opcode in DECODE goes to ILLEGAL.
  - ILLEGAL is terminal until rst: all strobes are 0 and illegal=1 (sticky).
- `MC_ILLEGAL_TRAP_EN` not defined:
  - An unknown opcode returns to FETCH as a no-op: 2 cycles, no writes, instr_done=0.
  - The illegal port is absent.

## Structure
- `mc_pkg` holds:
  - the opcode constants (ADDI 001000, ADDIU 001001, BEQ 000100, J 000010, LW 100011, SW 101011, LUI 001111, RTYPE 000000)
  - the ALUOp, ALUSrcB and PCSrc encodings
  - the enumerated 4-bit state type
- One sub-module, `mc_signal_decode`, is purely combinational: it maps state, opcode and mem_ready to the control word.
- The top module holds the state register and next-state logic.

## Test plan
- Reset: assert rst mid-MEMWB → state=FETCH the same cycle, RegWrite=0. After release, FETCH shows IorD=0, ALUSrcB=01.
- Instruction stream with mem_ready=1: R, lw, sw, beq, j, addi, addiu, lui → instr_done gaps of 4, 5, 4, 3, 3, 4, 4, 4 cycles.
- Per-state control words:
  - lui: ALUOp=11 in IMMEX.
  - addiu: Ext_op=1 in IMMEX.
  - beq: PCWriteCond=1, PCSrc=01.
- lw with mem_ready low for 3 cycles in MEMRD → lw takes 8 cycles. RegWrite pulses exactly once, in MEMWB.
- FETCH with mem_ready=0 for 2 cycles → IRWrite and PCWrite stay 0 until the cycle mem_ready=1, then pulse once.
- Opcode 111111:
  - With the macro: illegal=1 and stays set; strobes stay 0 for 10 cycles.
  - Without the macro: FETCH 2 cycles later, no instr_done pulse.
